// File: rtl/game_sequencer.sv
// Game-flow controller for the VGA snake: paces snake steps per frame, handles apples,
// level-up, game-over blink and restart. Define HIGH_SCORE_EN to add the hiscore_o output.
module game_sequencer #(
   parameter int STEP_FRAMES_INIT = 8,
   parameter int STEP_FRAMES_MIN  = 2,
   parameter int APPLES_PER_LEVEL = 4,
   parameter int SCORE_W          = 8,
   parameter int OVER_FRAMES      = 120
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               btn_start,
   input  logic               hit_wall,
   input  logic               hit_self,
   input  logic               apple_eaten,
   input  logic               pos_ack,
   output logic               pos_req,
   output logic               step_o,
   output logic               grow_o,
   output logic               clear_o,
   output logic [2:0]         state_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [2:0]         level_o,
   output logic               blank_o
`ifdef HIGH_SCORE_EN
   ,
   output logic [SCORE_W-1:0] hiscore_o
`endif
);

   localparam int FW = ($clog2(STEP_FRAMES_INIT) > 0) ? $clog2(STEP_FRAMES_INIT) : 1;
   localparam int AW = ($clog2(APPLES_PER_LEVEL) > 0) ? $clog2(APPLES_PER_LEVEL) : 1;
   localparam int OW = ($clog2(OVER_FRAMES) > 4) ? $clog2(OVER_FRAMES) : 4;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      START = 3'b001,
      PLAY  = 3'b010,
      APPLE = 3'b011,
      OVER  = 3'b100
   } state_t;

   state_t             state_q, state_d;
   logic               btn_prev_q;
   logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
   logic [OW-1:0]      over_cnt_q, over_cnt_d;
   logic [AW-1:0]      apple_cnt_q, apple_cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         level_q, level_d;
   logic               grow_pending_q, grow_pending_d;
   logic               step_q, step_d;
   logic               grow_q, grow_d;
   logic               clear_q, clear_d;
`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] hiscore_q, hiscore_d;
`endif

   logic          start_edge;
   logic          collision;
   logic          over_last;
   logic [FW-1:0] period_m1;

   assign start_edge = btn_start & ~btn_prev_q;
   assign collision  = hit_wall | hit_self;
   assign over_last  = frame_tick && (over_cnt_q == OW'(OVER_FRAMES - 1));

   // Step period shrinks by one frame per level down to the floor.
   always_comb begin
      int p;
      p = STEP_FRAMES_INIT - int'(level_q);
      if (p < STEP_FRAMES_MIN) p = STEP_FRAMES_MIN;
      period_m1 = FW'(p - 1);
   end

   // ---------------- state register and datapath flops ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         btn_prev_q     <= 1'b0;
         frame_cnt_q    <= '0;
         over_cnt_q     <= '0;
         apple_cnt_q    <= '0;
         score_q        <= '0;
         level_q        <= '0;
         grow_pending_q <= 1'b0;
         step_q         <= 1'b0;
         grow_q         <= 1'b0;
         clear_q        <= 1'b0;
`ifdef HIGH_SCORE_EN
         hiscore_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q        <= state_d;
         btn_prev_q     <= btn_start;
         frame_cnt_q    <= frame_cnt_d;
         over_cnt_q     <= over_cnt_d;
         apple_cnt_q    <= apple_cnt_d;
         score_q        <= score_d;
         level_q        <= level_d;
         grow_pending_q <= grow_pending_d;
         step_q         <= step_d;
         grow_q         <= grow_d;
         clear_q        <= clear_d;
`ifdef HIGH_SCORE_EN
         hiscore_q      <= hiscore_d;
`endif
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_edge) state_d = START;
         START:   if (pos_ack) state_d = PLAY;
         PLAY: begin
            if (collision)        state_d = OVER;
            else if (apple_eaten) state_d = APPLE;
         end
         APPLE:   if (pos_ack) state_d = PLAY;
         OVER:    if (over_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      // NOTE: every _d gets a default first so no path can infer a latch.
      frame_cnt_d    = frame_cnt_q;
      over_cnt_d     = '0;
      apple_cnt_d    = apple_cnt_q;
      score_d        = score_q;
      level_d        = level_q;
      grow_pending_d = grow_pending_q;
      step_d         = 1'b0;
      grow_d         = 1'b0;
      clear_d        = 1'b0;
`ifdef HIGH_SCORE_EN
      hiscore_d      = hiscore_q;
`endif

      unique case (state_q)
         IDLE: clear_d = start_edge;
         START: begin
            frame_cnt_d    = '0;
            apple_cnt_d    = '0;
            score_d        = '0;
            level_d        = '0;
            grow_pending_d = 1'b0;
         end
         PLAY: begin
            if (collision) begin
`ifdef HIGH_SCORE_EN
               if (score_q > hiscore_q) hiscore_d = score_q;
`endif
            end else begin
               if (frame_tick) begin
                  // >= guards the case where a level-up shortened the period mid-count.
                  if (frame_cnt_q >= period_m1) begin
                     frame_cnt_d    = '0;
                     step_d         = 1'b1;
                     grow_d         = grow_pending_q;
                     grow_pending_d = 1'b0;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 1'b1;
                  end
               end
               if (apple_eaten) begin
                  grow_pending_d = 1'b1;
                  if (score_q != '1) score_d = score_q + 1'b1;
                  if (apple_cnt_q == AW'(APPLES_PER_LEVEL - 1)) begin
                     apple_cnt_d = '0;
                     if (level_q != 3'd7) level_d = level_q + 1'b1;
                  end else begin
                     apple_cnt_d = apple_cnt_q + 1'b1;
                  end
               end
            end
         end
         OVER: begin
            if (over_last)       over_cnt_d = '0;
            else if (frame_tick) over_cnt_d = over_cnt_q + 1'b1;
            else                 over_cnt_d = over_cnt_q;
         end
         default: ;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      state_o = state_q;
      pos_req = (state_q == START) || (state_q == APPLE);
      blank_o = (state_q == OVER) && over_cnt_q[3];
      step_o  = step_q;
      grow_o  = grow_q;
      clear_o = clear_q;
      score_o = score_q;
      level_o = level_q;
`ifdef HIGH_SCORE_EN
      hiscore_o = hiscore_q;
`endif
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start handshake, step pacing, apples and level-up,
// collision priority, game-over blink/timeout, async reset, and optional high score.
module tb_game_sequencer;

   localparam int SCORE_W     = 8;
   localparam int OVER_FRAMES = 120;

   logic               clk = 1'b0;
   logic               reset;
   logic               frame_tick, btn_start, hit_wall, hit_self, apple_eaten, pos_ack;
   logic               pos_req, step_o, grow_o, clear_o, blank_o;
   logic [2:0]         state_o, level_o;
   logic [SCORE_W-1:0] score_o;
`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] hiscore_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   game_sequencer #(
      .STEP_FRAMES_INIT(8),
      .STEP_FRAMES_MIN (2),
      .APPLES_PER_LEVEL(4),
      .SCORE_W         (SCORE_W),
      .OVER_FRAMES     (OVER_FRAMES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_start  (btn_start),
      .hit_wall   (hit_wall),
      .hit_self   (hit_self),
      .apple_eaten(apple_eaten),
      .pos_ack    (pos_ack),
      .pos_req    (pos_req),
      .step_o     (step_o),
      .grow_o     (grow_o),
      .clear_o    (clear_o),
      .state_o    (state_o),
      .score_o    (score_o),
      .level_o    (level_o),
      .blank_o    (blank_o)
`ifdef HIGH_SCORE_EN
      ,
      .hiscore_o  (hiscore_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic ack();
      pos_ack = 1'b1;
      cyc();
      pos_ack = 1'b0;
   endtask

   task automatic eat();
      apple_eaten = 1'b1;
      cyc();
      apple_eaten = 1'b0;
   endtask

`ifdef HIGH_SCORE_EN
   task automatic play_game(input int apples);
      btn_start = 1'b1;
      cyc();
      btn_start = 1'b0;
      cyc();
      ack();
      repeat (apples) begin
         eat();
         ack();
      end
      hit_self = 1'b1;
      cyc();
      hit_self = 1'b0;
      check("hs_over_state", state_o, 3'b100);
      repeat (OVER_FRAMES) begin
         tick();
         cyc();
      end
      check("hs_idle_state", state_o, 3'b000);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; frame_tick = 1'b0; btn_start = 1'b0; hit_wall = 1'b0;
      hit_self = 1'b0; apple_eaten = 1'b0; pos_ack = 1'b0;
      cyc(); cyc();
      check("rst_state", state_o, 3'b000);
      check("rst_score", score_o, 0);
      check("rst_level", level_o, 0);
      check("rst_outs", {pos_req, step_o, grow_o, clear_o, blank_o}, 5'b0);
      reset = 1'b0;
      cyc();

      // start handshake, ack after 5 cycles
      btn_start = 1'b1;
      cyc();
      check("start_state", state_o, 3'b001);
      check("start_clear", clear_o, 1'b1);
      check("start_req", pos_req, 1'b1);
      cyc();
      check("start_clear_once", clear_o, 1'b0);
      check("start_req_hold", pos_req, 1'b1);
      btn_start = 1'b0;
      repeat (3) cyc();
      check("start_wait_state", state_o, 3'b001);
      ack();
      check("play_state", state_o, 3'b010);
      check("play_req_low", pos_req, 1'b0);
      ack();
      check("stray_ack_ignored", state_o, 3'b010);

      // level 0: 16 ticks, steps after ticks 8 and 16
      for (int i = 0; i < 16; i++) begin
         tick();
         check("l0_step", step_o, (i == 7 || i == 15));
         if (i == 7 || i == 15) check("l0_grow", grow_o, 1'b0);
         cyc();
      end

      // apple 1 with a dropped tick while waiting for the ack
      eat();
      check("a1_state", state_o, 3'b011);
      check("a1_score", score_o, 1);
      check("a1_req", pos_req, 1'b1);
      tick();
      check("a1_tick_dropped_state", state_o, 3'b011);
      check("a1_no_step", step_o, 1'b0);
      ack();
      check("a1_back_play", state_o, 3'b010);
      check("a1_req_low", pos_req, 1'b0);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("a1_step", step_o, (i == 7 || i == 15));
         if (i == 7)  check("a1_grow_first", grow_o, 1'b1);
         if (i == 15) check("a1_grow_second", grow_o, 1'b0);
         cyc();
      end

      // apples 2..4, level-up on the fourth
      eat(); check("a2_score", score_o, 2); ack();
      eat(); check("a3_score", score_o, 3); check("a3_level", level_o, 0); ack();
      eat(); check("a4_score", score_o, 4); check("a4_level", level_o, 1); ack();
      check("a4_play", state_o, 3'b010);
      for (int i = 0; i < 14; i++) begin
         tick();
         check("l1_step", step_o, (i == 6 || i == 13));
         if (i == 6)  check("l1_grow_first", grow_o, 1'b1);
         if (i == 13) check("l1_grow_second", grow_o, 1'b0);
         cyc();
      end

      // collision + apple + step-due tick in the same cycle
      repeat (6) begin
         tick();
         cyc();
      end
      frame_tick = 1'b1; hit_wall = 1'b1; apple_eaten = 1'b1;
      cyc();
      frame_tick = 1'b0; hit_wall = 1'b0; apple_eaten = 1'b0;
      check("over_state", state_o, 3'b100);
      check("over_no_step", step_o, 1'b0);
      check("over_score", score_o, 4);
      check("over_level", level_o, 1);
      check("over_no_req", pos_req, 1'b0);
      check("over_blank0", blank_o, 1'b0);

      // game-over blink and timeout, start button ignored
      for (int i = 0; i < OVER_FRAMES; i++) begin
         btn_start = (i >= 40 && i < 45);
         tick();
         check("over_tick_state", state_o, (i < OVER_FRAMES - 1) ? 3'b100 : 3'b000);
         check("over_tick_blank", blank_o, (i < OVER_FRAMES - 1) ? (((i + 1) >> 3) & 1) : 0);
         cyc();
      end
      btn_start = 1'b0;
      cyc();
      check("idle_after_over", state_o, 3'b000);
      check("idle_score_hold", score_o, 4);
      check("idle_level_hold", level_o, 1);

      // second game, reach score 3, then async reset right on a step pulse
      btn_start = 1'b1;
      cyc();
      check("g2_start", state_o, 3'b001);
      check("g2_clear", clear_o, 1'b1);
      btn_start = 1'b0;
      cyc();
      check("g2_score_cleared", score_o, 0);
      check("g2_level_cleared", level_o, 0);
      ack();
      repeat (3) begin
         eat();
         ack();
      end
      check("g2_score3", score_o, 3);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i < 7) cyc();
      end
      check("g2_step_before_reset", step_o, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_state", state_o, 3'b000);
      check("async_rst_score", score_o, 0);
      check("async_rst_step", step_o, 1'b0);
      check("async_rst_req", pos_req, 1'b0);
      check("async_rst_grow", grow_o, 1'b0);
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      check("post_rst_idle", state_o, 3'b000);

`ifdef HIGH_SCORE_EN
      check("hs_after_reset", hiscore_o, 0);
      play_game(5);
      check("hs_game1", hiscore_o, 5);
      play_game(2);
      check("hs_game2", hiscore_o, 5);
      check("hs_game2_score", score_o, 2);
      reset = 1'b1;
      #1;
      check("hs_reset", hiscore_o, 0);
      cyc();
      reset = 1'b0;
      cyc();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
